pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the four in-order backend pipe_reg stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_md_timer.sv | 80 ++++++++
 rtl/pipe_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types for the backend stall/flush sequencer.
//   mem_state_e : dcache handshake FSM states
//   md_state_e  : multi-cycle mul/div timer states
//   stage_e     : index of each backend pipe_reg in the hold/flush vectors
//   LREG_W      : logical register index width
package pipe_ctrl_pkg;

  localparam int LREG_W = 5;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_REQ  = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    STG_IF_ID  = 2'd0,
    STG_ID_EX  = 2'd1,
    STG_EX_MEM = 2'd2,
    STG_MEM_WB = 2'd3
  } stage_e;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// pipe_ctrl_md_timer
//   Times a multi-cycle mul/div op sitting in EX and raises ex_stall until
//   MULDIV_LAT cycles of EX occupancy have elapsed. The countdown keeps
//   running while the whole pipe is frozen by a MEM stall; if it expires
//   before EX can move, MD_DONE remembers that the op is finished so it is
//   not restarted.
// Parameters
//   MULDIV_LAT : EX occupancy of a mul/div op in cycles (>=1, 1 = no stall)
// Ports
//   clock    in  core clock
//   reset_n  in  asynchronous active-low reset
//   start    in  a valid mul/div op is present in EX
//   advance  in  EX hands its instr onward this cycle
//   ex_stall out EX must hold this cycle
//   state    out current FSM state (debug visibility)
module pipe_ctrl_md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      start,
  input  logic      advance,
  output logic      ex_stall,
  output md_state_e state
);

  // The counter covers the cycles after the start cycle and before the
  // final non-stalled cycle, hence the -2.
  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MULDIV_LAT >= 2) ? CNT_W'(MULDIV_LAT - 2) : '0;
  localparam bit MULTI = (MULDIV_LAT > 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start && MULTI) begin
          ex_stall = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else if (advance) begin
          state_d = MD_IDLE;
        end else begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        if (advance) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//   pipe_regs. Detects load-use hazards, times mul/div ops in EX (via
//   pipe_ctrl_md_timer), runs the dcache req/ack handshake for MEM and turns
//   all of it, plus EX redirects, into per-stage hold/flush strobes.
//
//   Handshake: mem_req is a registered request that rises the cycle after a
//   load/store enters MEM and stays high until the cycle mem_ack is seen;
//   mem_ack is only meaningful while mem_req=1 and is ignored otherwise.
//
//   Priority: mem stall > ex stall > redirect > load-use. A redirect that
//   arrives under a stall is not lost; its source keeps it asserted and it
//   fires the cycle EX advances.
//
// Configuration macro
//   PIPE_CTRL_PERF_EN : when defined, perf_* are wrapping event counters;
//                       otherwise they are tied to zero.
// Parameters
//   MULDIV_LAT : EX occupancy of a mul/div op in cycles (>=1)
//   PERF_W     : width of each perf counter
// Ports
//   clock, reset_n                       clock, async active-low reset
//   id_*                                 instr in IF/ID and its sources
//   ex_*                                 instr in ID/EX and its dest/kind
//   redirect_valid                       branch redirect requested from EX
//   mem_valid, mem_is_ls                 instr in EX/MEM is a load/store
//   mem_req / mem_ack                    dcache request / completion
//   hold_*                               stall strobes (hold_if_id also holds PC)
//   flush_*                              bubble/flush strobes
//   perf_*                               event counters
//   dbg_mem_state, dbg_md_state          FSM states for debug visibility
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [LREG_W-1:0] id_rs1,
  input  logic [LREG_W-1:0] id_rs2,
  input  logic              id_src1_is_reg,
  input  logic              id_src2_is_reg,
  input  logic              ex_valid,
  input  logic [LREG_W-1:0] ex_rd,
  input  logic              ex_need_to_wb,
  input  logic              ex_is_load,
  input  logic              ex_is_muldiv,
  input  logic              redirect_valid,
  input  logic              mem_valid,
  input  logic              mem_is_ls,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              hold_if_id,
  output logic              hold_id_ex,
  output logic              hold_ex_mem,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              flush_mem_wb,
  output logic [PERF_W-1:0] perf_mem_stall,
  output logic [PERF_W-1:0] perf_ex_stall,
  output logic [PERF_W-1:0] perf_load_use,
  output logic [PERF_W-1:0] perf_redirect,
  output mem_state_e        dbg_mem_state,
  output md_state_e         dbg_md_state
);

  mem_state_e mem_state_q, mem_state_d;
  logic       mem_stall;
  logic       ex_stall;
  logic       ex_advance;
  logic       load_use;
  logic [2:0] hold_v;
  logic [3:0] flush_v;

  // ---------------- dcache handshake ----------------
  always_comb begin
    mem_state_d = mem_state_q;
    case (mem_state_q)
      M_IDLE:  if (mem_valid && mem_is_ls) mem_state_d = M_REQ;
      M_REQ:   if (mem_ack) mem_state_d = M_IDLE;
      default: mem_state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mem_state_q <= M_IDLE;
    else          mem_state_q <= mem_state_d;
  end

  assign mem_req   = (mem_state_q == M_REQ);
  // The load/store may only leave MEM in the cycle its ack comes back.
  assign mem_stall = mem_valid & mem_is_ls & ~(mem_req & mem_ack);

  // ---------------- mul/div timer ----------------
  assign ex_advance = ~(mem_stall | ex_stall);

  pipe_ctrl_md_timer #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_md_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (ex_valid & ex_is_muldiv),
    .advance  (ex_advance),
    .ex_stall (ex_stall),
    .state    (dbg_md_state)
  );

  // ---------------- load-use hazard ----------------
  // x0 is never a real dependency.
  assign load_use = ex_valid & ex_is_load & ex_need_to_wb & (ex_rd != '0) &
                    id_valid &
                    ((id_src1_is_reg & (id_rs1 == ex_rd)) |
                     (id_src2_is_reg & (id_rs2 == ex_rd)));

  // ---------------- priority mux ----------------
  // Each branch touches hold and flush of disjoint registers, so no
  // pipe_reg ever sees both strobes at once.
  always_comb begin
    hold_v  = '0;
    flush_v = '0;
    if (mem_stall) begin
      hold_v[STG_IF_ID]   = 1'b1;
      hold_v[STG_ID_EX]   = 1'b1;
      hold_v[STG_EX_MEM]  = 1'b1;
      flush_v[STG_MEM_WB] = 1'b1;
    end else if (ex_stall) begin
      hold_v[STG_IF_ID]   = 1'b1;
      hold_v[STG_ID_EX]   = 1'b1;
      flush_v[STG_EX_MEM] = 1'b1;
    end else if (redirect_valid) begin
      // The ID instr is wrong-path, so a pending load-use is irrelevant.
      flush_v[STG_IF_ID]  = 1'b1;
      flush_v[STG_ID_EX]  = 1'b1;
    end else if (load_use) begin
      hold_v[STG_IF_ID]   = 1'b1;
      flush_v[STG_ID_EX]  = 1'b1;
    end
  end

  assign hold_if_id   = hold_v[STG_IF_ID];
  assign hold_id_ex   = hold_v[STG_ID_EX];
  assign hold_ex_mem  = hold_v[STG_EX_MEM];
  assign flush_if_id  = flush_v[STG_IF_ID];
  assign flush_id_ex  = flush_v[STG_ID_EX];
  assign flush_ex_mem = flush_v[STG_EX_MEM];
  assign flush_mem_wb = flush_v[STG_MEM_WB];

  assign dbg_mem_state = mem_state_q;

  // ---------------- performance counters ----------------
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] cnt_mem_q, cnt_ex_q, cnt_lu_q, cnt_rd_q;
  logic ev_mem, ev_ex, ev_lu, ev_rd;

  // Count only the condition that actually won the priority mux.
  assign ev_mem = mem_stall;
  assign ev_ex  = ex_stall & ~mem_stall;
  assign ev_rd  = flush_v[STG_IF_ID];
  assign ev_lu  = load_use & ~mem_stall & ~ex_stall & ~redirect_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_mem_q <= '0;
      cnt_ex_q  <= '0;
      cnt_lu_q  <= '0;
      cnt_rd_q  <= '0;
    end else begin
      if (ev_mem) cnt_mem_q <= cnt_mem_q + PERF_W'(1);
      if (ev_ex)  cnt_ex_q  <= cnt_ex_q  + PERF_W'(1);
      if (ev_lu)  cnt_lu_q  <= cnt_lu_q  + PERF_W'(1);
      if (ev_rd)  cnt_rd_q  <= cnt_rd_q  + PERF_W'(1);
    end
  end

  assign perf_mem_stall = cnt_mem_q;
  assign perf_ex_stall  = cnt_ex_q;
  assign perf_load_use  = cnt_lu_q;
  assign perf_redirect  = cnt_rd_q;
`else
  assign perf_mem_stall = '0;
  assign perf_ex_stall  = '0;
  assign perf_load_use  = '0;
  assign perf_redirect  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl (MULDIV_LAT=4, PERF_W=32). Each cycle the
//   inputs are driven just after the rising edge, the expected strobe vector
//   is pushed to the scoreboard, and it is popped and compared at the
//   falling edge. Expected perf counts are accumulated from the expected
//   strobe vectors.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int PERF_W = 32;

  // Expected vector layout:
  // {hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id,
  //  flush_id_ex, flush_ex_mem, flush_mem_wb, mem_req}
  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1000_1000;
  localparam logic [7:0] E_MD   = 8'b1100_0100;
  localparam logic [7:0] E_MS0  = 8'b1110_0010;
  localparam logic [7:0] E_MS   = 8'b1110_0011;
  localparam logic [7:0] E_ACK  = 8'b0000_0001;
  localparam logic [7:0] E_RDAK = 8'b0001_1001;
  localparam logic [7:0] E_RD   = 8'b0001_1000;
  localparam logic [7:0] E_MDAK = 8'b1100_0101;

  logic              clock;
  logic              reset_n;
  logic              id_valid;
  logic [LREG_W-1:0] id_rs1, id_rs2;
  logic              id_src1_is_reg, id_src2_is_reg;
  logic              ex_valid;
  logic [LREG_W-1:0] ex_rd;
  logic              ex_need_to_wb, ex_is_load, ex_is_muldiv;
  logic              redirect_valid;
  logic              mem_valid, mem_is_ls, mem_ack;
  logic              mem_req;
  logic              hold_if_id, hold_id_ex, hold_ex_mem;
  logic              flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [PERF_W-1:0] perf_mem_stall, perf_ex_stall, perf_load_use, perf_redirect;
  mem_state_e        dbg_mem_state;
  md_state_e         dbg_md_state;

  logic [7:0] obs;
  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_mem = 0, m_ex = 0, m_lu = 0, m_rd = 0;

  assign obs = {hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id,
                flush_id_ex, flush_ex_mem, flush_mem_wb, mem_req};

  pipe_ctrl #(
    .MULDIV_LAT (4),
    .PERF_W     (PERF_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_src1_is_reg (id_src1_is_reg),
    .id_src2_is_reg (id_src2_is_reg),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_need_to_wb  (ex_need_to_wb),
    .ex_is_load     (ex_is_load),
    .ex_is_muldiv   (ex_is_muldiv),
    .redirect_valid (redirect_valid),
    .mem_valid      (mem_valid),
    .mem_is_ls      (mem_is_ls),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .hold_if_id     (hold_if_id),
    .hold_id_ex     (hold_id_ex),
    .hold_ex_mem    (hold_ex_mem),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .flush_mem_wb   (flush_mem_wb),
    .perf_mem_stall (perf_mem_stall),
    .perf_ex_stall  (perf_ex_stall),
    .perf_load_use  (perf_load_use),
    .perf_redirect  (perf_redirect),
    .dbg_mem_state  (dbg_mem_state),
    .dbg_md_state   (dbg_md_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_src1_is_reg = 0; id_src2_is_reg = 0;
    ex_valid = 0; ex_rd = '0; ex_need_to_wb = 0; ex_is_load = 0; ex_is_muldiv = 0;
    redirect_valid = 0; mem_valid = 0; mem_is_ls = 0; mem_ack = 0;
  endtask

  task automatic load_use_in();
    idle_in();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; ex_need_to_wb = 1;
    id_valid = 1; id_rs1 = 5'd5; id_src1_is_reg = 1;
  endtask

  // Push the expectation now, compare at the falling edge.
  task automatic check_half(input logic [7:0] e, input string tag);
    logic [7:0] x;
    exp_q.push_back(e);
    @(negedge clock);
    x = exp_q.pop_front();
    n_cmp++;
    assert (obs === x) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, x);
    end
    if (x[1]) m_mem++;
    if (x[2]) m_ex++;
    if (x[4]) m_rd++;
    if (x[7] && x[3] && !x[6] && !x[4]) m_lu++;
  endtask

  task automatic run_cycle(input logic [7:0] e, input string tag);
    check_half(e, tag);
    @(posedge clock);
    #1;
  endtask

  task automatic check_md(input md_state_e e, input string tag);
    n_cmp++;
    assert (dbg_md_state === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, dbg_md_state, e);
    end
  endtask

  task automatic check_mem(input mem_state_e e, input string tag);
    n_cmp++;
    assert (dbg_mem_state === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, dbg_mem_state, e);
    end
  endtask

  function automatic logic [PERF_W-1:0] exp_perf(input int m);
`ifdef PIPE_CTRL_PERF_EN
    return PERF_W'(m);
`else
    return '0;
`endif
  endfunction

  task automatic check_perf(input string tag);
    logic [4*PERF_W-1:0] o, e;
    o = {perf_mem_stall, perf_ex_stall, perf_load_use, perf_redirect};
    e = {exp_perf(m_mem), exp_perf(m_ex), exp_perf(m_lu), exp_perf(m_rd)};
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_in();
    reset_n = 1'b0;
    #12;
    exp_q.push_back(E_IDLE);
    n_cmp++;
    assert (obs === exp_q[0]) else begin
      n_fail++;
      $error("FAIL reset_out: observed %b expected %b", obs, exp_q[0]);
    end
    void'(exp_q.pop_front());
    check_md(MD_IDLE, "reset_md");
    check_mem(M_IDLE, "reset_mem");
    check_perf("reset_perf");
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    run_cycle(E_IDLE, "idle");

    // Load-use on rs1: one cycle of hold_if_id/flush_id_ex.
    load_use_in();
    run_cycle(E_LU, "lu_rs1");
    idle_in(); id_valid = 1; id_rs1 = 5'd5; id_src1_is_reg = 1;
    run_cycle(E_IDLE, "lu_gone");
    // No hazard: rd=x0, src not read, no writeback.
    load_use_in(); ex_rd = 5'd0; id_rs1 = 5'd0;
    run_cycle(E_IDLE, "lu_x0");
    load_use_in(); id_src1_is_reg = 0;
    run_cycle(E_IDLE, "lu_noreg");
    load_use_in(); ex_need_to_wb = 0;
    run_cycle(E_IDLE, "lu_nowb");
    // Hazard through rs2.
    load_use_in(); id_rs1 = 5'd3; id_rs2 = 5'd5; id_src2_is_reg = 1;
    run_cycle(E_LU, "lu_rs2");
    // Redirect wins over load-use.
    load_use_in(); redirect_valid = 1;
    run_cycle(E_RD, "rd_over_lu");

    // Mul/div with MULDIV_LAT=4.
    idle_in(); ex_valid = 1; ex_is_muldiv = 1;
    run_cycle(E_MD, "md_c0");
    run_cycle(E_MD, "md_c1");
    run_cycle(E_MD, "md_c2");
    run_cycle(E_IDLE, "md_c3");
    idle_in();
    check_md(MD_IDLE, "md_idle_c4");
    run_cycle(E_IDLE, "md_c4");

    // Load in MEM at cycle 0, ack at cycle 4.
    idle_in(); mem_valid = 1; mem_is_ls = 1;
    run_cycle(E_MS0, "ld_c0");
    run_cycle(E_MS, "ld_c1");
    run_cycle(E_MS, "ld_c2");
    run_cycle(E_MS, "ld_c3");
    mem_ack = 1;
    run_cycle(E_ACK, "ld_c4");
    idle_in();
    run_cycle(E_IDLE, "ld_c5");

    // Ack outside M_REQ is ignored; minimum occupancy is two cycles.
    idle_in(); mem_valid = 1; mem_is_ls = 1; mem_ack = 1;
    run_cycle(E_MS0, "ack_early_c0");
    run_cycle(E_ACK, "ack_early_c1");
    idle_in();
    check_mem(M_IDLE, "ack_early_mem");
    run_cycle(E_IDLE, "ack_early_c2");

    // Redirect deferred under a mem stall.
    idle_in(); mem_valid = 1; mem_is_ls = 1; redirect_valid = 1;
    run_cycle(E_MS0, "rd_ms_c0");
    run_cycle(E_MS, "rd_ms_c1");
    mem_ack = 1;
    run_cycle(E_RDAK, "rd_ms_ack");
    idle_in();
    run_cycle(E_IDLE, "rd_ms_after");

    // Mul/div countdown continues during a mem stall.
    idle_in(); ex_valid = 1; ex_is_muldiv = 1; mem_valid = 1; mem_is_ls = 1;
    run_cycle(E_MS0, "mdms_c0");
    run_cycle(E_MS, "mdms_c1");
    mem_ack = 1;
    run_cycle(E_MDAK, "mdms_c2");
    mem_valid = 0; mem_is_ls = 0; mem_ack = 0;
    run_cycle(E_IDLE, "mdms_c3");
    idle_in();
    check_md(MD_IDLE, "mdms_idle");
    run_cycle(E_IDLE, "mdms_c4");

    // Countdown expires while MEM stalls: MD_DONE until EX advances.
    idle_in(); ex_valid = 1; ex_is_muldiv = 1;
    run_cycle(E_MD, "mddn_c0");
    run_cycle(E_MD, "mddn_c1");
    run_cycle(E_MD, "mddn_c2");
    mem_valid = 1; mem_is_ls = 1;
    run_cycle(E_MS0, "mddn_c3");
    check_md(MD_DONE, "mddn_done");
    mem_ack = 1;
    run_cycle(E_ACK, "mddn_c4");
    idle_in();
    check_md(MD_IDLE, "mddn_idle");
    run_cycle(E_IDLE, "mddn_c5");

    check_perf("perf_mid");

    // Reset during MD_BUSY with mem_req=1.
    idle_in(); ex_valid = 1; ex_is_muldiv = 1; mem_valid = 1; mem_is_ls = 1;
    run_cycle(E_MS0, "rst_c0");
    check_half(E_MS, "rst_c1");
    check_md(MD_BUSY, "rst_busy");
    #2;
    idle_in();
    reset_n = 1'b0;
    m_mem = 0; m_ex = 0; m_lu = 0; m_rd = 0;
    #1;
    exp_q.push_back(E_IDLE);
    n_cmp++;
    assert (obs === exp_q[0]) else begin
      n_fail++;
      $error("FAIL rst_async_out: observed %b expected %b", obs, exp_q[0]);
    end
    void'(exp_q.pop_front());
    check_md(MD_IDLE, "rst_async_md");
    check_mem(M_IDLE, "rst_async_mem");
    check_perf("rst_async_perf");
    @(posedge clock); #1;
    @(negedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_cycle(E_IDLE, "post_rst_idle");
    check_md(MD_IDLE, "post_rst_md");
    check_mem(M_IDLE, "post_rst_mem");

    // New op after reset behaves normally.
    mem_valid = 1; mem_is_ls = 1;
    run_cycle(E_MS0, "post_rst_ld0");
    mem_ack = 1;
    run_cycle(E_ACK, "post_rst_ld1");
    idle_in();
    load_use_in();
    run_cycle(E_LU, "post_rst_lu");
    idle_in();
    run_cycle(E_IDLE, "final_idle");

    check_perf("perf_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
